// File: rtl/processor_check_unit.sv
// Self-checking harness: runs the processor for a chosen number of cycles, then freezes it and
// compares a table of expected register values read through a dedicated regfile port.
module processor_check_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_CHECKS = 8,
  parameter int unsigned IDX_WIDTH  = 3,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [IDX_WIDTH-1:0]  cfg_idx,
  input  logic                  cfg_en,
  input  logic [ADDR_WIDTH-1:0] cfg_reg,
  input  logic [DATA_WIDTH-1:0] cfg_value,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  run_cycles,
  output logic [ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [DATA_WIDTH-1:0] rf_read_data,
  output logic                  proc_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [IDX_WIDTH:0]    error_count,
  output logic [IDX_WIDTH-1:0]  first_fail_idx,
  output logic [DATA_WIDTH-1:0] first_fail_data,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [1:0] {StIdle, StRun, StCheck, StDone} state_e;

  localparam logic [IDX_WIDTH:0]   ErrMax  = '1;
  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_CHECKS - 1);

  state_e                state_q;
  logic [NUM_CHECKS-1:0] en_q;
  logic [ADDR_WIDTH-1:0] reg_q   [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] value_q [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] mask_q  [NUM_CHECKS];
  logic [CNT_WIDTH-1:0]  limit_q;
  logic [IDX_WIDTH-1:0]  idx_q;

  logic                  cfg_ok;
  logic                  mismatch;
  logic [IDX_WIDTH:0]    err_next;

  always_comb begin
    cfg_ok = cfg_we && (state_q == StIdle || state_q == StDone) &&
             (32'(cfg_idx) < NUM_CHECKS);
    mismatch = en_q[idx_q] && (((rf_read_data ^ value_q[idx_q]) & mask_q[idx_q]) != '0);
    err_next = error_count;
    if (mismatch && error_count != ErrMax) begin
      err_next = error_count + (IDX_WIDTH + 1)'(1);
    end
  end

  // Address is only driven while scanning so the port idles at zero.
  always_comb begin
    rf_read_addr = '0;
    if (state_q == StCheck) begin
      rf_read_addr = reg_q[idx_q];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      en_q            <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        reg_q[i]   <= '0;
        value_q[i] <= '0;
        mask_q[i]  <= '0;
      end
      limit_q         <= '0;
      idx_q           <= '0;
      proc_hold       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_count     <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
      cycle_count     <= '0;
    end else begin
      if (cfg_ok) begin
        en_q[cfg_idx]    <= cfg_en;
        reg_q[cfg_idx]   <= cfg_reg;
        value_q[cfg_idx] <= cfg_value;
        mask_q[cfg_idx]  <= cfg_mask;
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            cycle_count     <= '0;
            error_count     <= '0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
            done            <= 1'b0;
            pass            <= 1'b0;
            busy            <= 1'b1;
            limit_q         <= run_cycles;
            idx_q           <= '0;
            if (run_cycles == '0) begin
              state_q   <= StCheck;
              proc_hold <= 1'b1;
            end else begin
              state_q   <= StRun;
              proc_hold <= 1'b0;
            end
          end
        end
        StRun: begin
          cycle_count <= cycle_count + CNT_WIDTH'(1);
          if (cycle_count == limit_q - CNT_WIDTH'(1)) begin
            state_q   <= StCheck;
            proc_hold <= 1'b1;
          end
        end
        StCheck: begin
          error_count <= err_next;
          // A zero count means no failure has been recorded yet this run.
          if (mismatch && error_count == '0) begin
            first_fail_idx  <= idx_q;
            first_fail_data <= rf_read_data;
          end
          if (idx_q == LastIdx) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next == '0);
          end else begin
            idx_q <= idx_q + IDX_WIDTH'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/processor_check_unit.md
Name: processor_check_unit

Overview:
- Synthesizable self-checking harness that sits beside the processor and register file in the skeleton.
- After a runtime-selected number of clock cycles, it freezes the processor and scans a parameterised table of expected register values through a dedicated regfile read port.
- It counts mismatches and reports pass/fail, so on-board FPGA runs can be checked without a simulator.

Parameters:
- DATA_WIDTH, 32: register data width.
- ADDR_WIDTH, 5: regfile address width (2^ADDR_WIDTH registers).
- NUM_CHECKS, 8: number of expected-value table entries (≥1).
- IDX_WIDTH, 3: entry index width; must satisfy 2^IDX_WIDTH ≥ NUM_CHECKS.
- CNT_WIDTH, 32: width of the run-cycle counter and the run_cycles input.

Ports:
- clock, in, 1: system clock, rising-edge.
- reset, in, 1: asynchronous, active-high reset.
- cfg_we, in, 1: table write strobe.
- cfg_idx, in, IDX_WIDTH: table entry to write.
- cfg_en, in, 1: entry enable bit.
- cfg_reg, in, ADDR_WIDTH: register number the entry checks.
- cfg_value, in, DATA_WIDTH: expected value.
- cfg_mask, in, DATA_WIDTH: compare mask; 1 = bit is checked.
- start, in, 1: begin a run.
- run_cycles, in, CNT_WIDTH: cycles to run before checking; sampled on start.
- rf_read_addr, out, ADDR_WIDTH: regfile read address.
- rf_read_data, in, DATA_WIDTH: regfile combinational read data.
- proc_hold, out, 1: stall request to the processor.
- busy, out, 1: high while in RUN or CHECK.
- done, out, 1: check complete.
- pass, out, 1: done and error_count == 0.
- error_count, out, IDX_WIDTH+1: mismatching enabled entries.
- first_fail_idx, out, IDX_WIDTH: index of the lowest failing entry.
- first_fail_data, out, DATA_WIDTH: register data read for that entry.
- cycle_count, out, CNT_WIDTH: cycles elapsed in RUN.

Behaviour:

Reset:
- States: IDLE, RUN, CHECK, DONE.
- Asynchronous reset from any state: state goes to IDLE.
- All table entries get en=0.
- All outputs go to 0: proc_hold, busy, done, pass, error_count, first_fail_idx, first_fail_data, cycle_count, rf_read_addr.

Table writes:
- cfg_we is honoured only in IDLE or DONE; it is ignored in RUN and CHECK.
- A write takes effect at the clock edge.
- cfg_idx ≥ NUM_CHECKS is ignored.

IDLE / DONE, on start=1:
- State goes to RUN.
- cycle_count, error_count, first_fail_idx and first_fail_data clear to 0.
- done and pass clear to 0.
- run_cycles is latched as the limit L.
- If L == 0, state goes directly to CHECK instead.
- start has no effect in RUN or CHECK.

RUN:
- busy=1, proc_hold=0.
- cycle_count increments each cycle.
- When cycle_count == L-1, the next edge goes to CHECK and cycle_count ends at L. RUN therefore lasts exactly L cycles.

CHECK:
- busy=1, proc_hold=1.
- Scan pointer i starts at 0; one entry is processed per cycle.
- rf_read_addr = entry[i].reg, combinational from i.
- At each edge, if entry[i].en and ((rf_read_data ^ value) & mask) != 0:
  - error_count increments, saturating at all-ones.
  - If this is the first failure of the run, record first_fail_idx=i and first_fail_data=rf_read_data.
- Disabled entries still take one cycle each. CHECK lasts exactly NUM_CHECKS cycles.
- After i == NUM_CHECKS-1, state goes to DONE.

DONE:
- proc_hold=1, busy=0, done=1.
- pass = (error_count == 0), registered on entry to DONE.
- State, results and outputs hold until start or reset.

Boundary conditions:
- An all-zero mask always passes.
- If no entry is enabled, pass=1.
- Reset mid-RUN or mid-CHECK aborts with no done pulse and clears the table.

Test Plan:
- Entry 0 = {en=1, reg=1, value=2, mask=FFFFFFFF}; regfile r1=2; start with run_cycles=5 → proc_hold rises exactly 5 cycles after start; done 8 cycles later; pass=1, error_count=0.
- Same setup but r1=3 → error_count=1, first_fail_idx=0, first_fail_data=3, pass=0.
- Entries 2 (r4 expects 0x10) and 5 (r7 expects 0xAA) enabled, both wrong; r4=0x11 → error_count=2, first_fail_idx=2, first_fail_data=0x11.
- Entry with mask=0x000000FF, value=0x12, register=0xABCD0012 → pass=1; change the register to 0xABCD0013 → fail.
- run_cycles=0 → CHECK entered on the edge after start and cycle_count=0; cfg_we during CHECK leaves the table unchanged.
- Assert reset asynchronously mid-RUN (cycle 3 of 10) → all outputs 0 immediately; table cleared; a following start with no entries gives pass=1.
